// File: rtl/keypad_scan_4x4_if.sv
// Keypad matrix bundle: column returns in, row drive and decoded key status out.
// The master side is the scanner; the slave side is the keypad/board logic.
interface keypad_scan_4x4_if;
    logic [3:0] Key_Col;
    logic [3:0] Key_Row;
    logic [3:0] Key_Code;
    logic       Key_Valid;
    logic       Key_Held;

    modport master (
        input  Key_Col,
        output Key_Row,
        output Key_Code,
        output Key_Valid,
        output Key_Held
    );

    modport slave (
        output Key_Col,
        input  Key_Row,
        input  Key_Code,
        input  Key_Valid,
        input  Key_Held
    );
endinterface

// File: rtl/keypad_scan_4x4.sv
// 4x4 hex keypad scanner: one-cold active-low row drive at a divided rate,
// synchronized active-low column sampling, whole-frame debounce, and a
// registered key code with a one-cycle valid strobe and a held level.
module keypad_scan_4x4 #(
    parameter int SCAN_TICKS     = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               sys_clk,
    input  logic               reset,
    keypad_scan_4x4_if.master  kp
);

    localparam int CNT_W = $clog2(SCAN_TICKS);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(SCAN_TICKS - 1);
    localparam logic [DB_W-1:0]  DB_FULL   = DB_W'(DEBOUNCE_SCANS);

    typedef enum logic [3:0] {
        ROW_IDLE = 4'b1111,
        ROW0     = 4'b1110,
        ROW1     = 4'b1101,
        ROW2     = 4'b1011,
        ROW3     = 4'b0111
    } row_e;

    logic [3:0]       col_meta_q, col_sync_q;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    row_e             row_q, row_d;
    logic             found_q, found_d;
    logic [3:0]       acc_code_q, acc_code_d;
    logic             prev_found_q, prev_found_d;
    logic [3:0]       prev_code_q, prev_code_d;
    logic [DB_W-1:0]  stable_q, stable_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic             tick, sample, frame_end, col_hit, frm_found, frm_same;
    logic [1:0]       row_idx, col_idx;
    logic [3:0]       frm_code;

    assign tick      = (dwell_q == LAST_TICK);
    assign frame_end = tick && (row_q == ROW3);
    assign col_hit   = ~&col_sync_q;

    // Two-flop synchronizer for the asynchronous column returns
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= kp.Key_Col;
            col_sync_q <= col_meta_q;
        end
    end

    // Row dwell counter, wraps after SCAN_TICKS cycles
    always_comb begin
        dwell_d = tick ? '0 : dwell_q + CNT_W'(1);
    end

    // Row FSM next state: advance one row per tick, recover illegal values to row 0
    always_comb begin
        row_d = row_q;
        if (tick) begin
            case (row_q)
                ROW0:    row_d = ROW1;
                ROW1:    row_d = ROW2;
                ROW2:    row_d = ROW3;
                default: row_d = ROW0;
            endcase
        end
    end

    // Decode the driven row index and the lowest pressed column
    always_comb begin
        sample  = tick;
        row_idx = 2'd0;
        case (row_q)
            ROW0:    row_idx = 2'd0;
            ROW1:    row_idx = 2'd1;
            ROW2:    row_idx = 2'd2;
            ROW3:    row_idx = 2'd3;
            default: sample  = 1'b0;
        endcase
        col_idx = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_sync_q[c]) col_idx = 2'(c);
        end
    end

    // Frame accumulation, frame-level debounce and key acceptance
    always_comb begin
        found_d      = found_q;
        acc_code_d   = acc_code_q;
        prev_found_d = prev_found_q;
        prev_code_d  = prev_code_q;
        stable_d     = stable_q;
        key_code_d   = key_code_q;
        key_held_d   = key_held_q;
        key_valid_d  = 1'b0;

        // The row-3 sample still belongs to the frame that ends on this tick.
        frm_found = found_q | (sample & col_hit);
        frm_code  = found_q ? acc_code_q : {row_idx, col_idx};
        // Any two no-press frames match regardless of the stored code.
        frm_same  = (frm_found == prev_found_q) && (!frm_found || frm_code == prev_code_q);

        if (sample && col_hit && !found_q) begin
            found_d    = 1'b1;
            acc_code_d = {row_idx, col_idx};
        end

        if (frame_end) begin
            found_d    = 1'b0;
            acc_code_d = 4'd0;
            if (frm_same) begin
                if (stable_q != DB_FULL) stable_d = stable_q + DB_W'(1);
            end else begin
                stable_d     = DB_W'(1);
                prev_found_d = frm_found;
                prev_code_d  = frm_code;
            end
            // No roll-over: a held key must be released before another is accepted.
            if (stable_d == DB_FULL) begin
                if (frm_found && !key_held_q) begin
                    key_code_d  = frm_code;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end else if (!frm_found && key_held_q) begin
                    key_held_d  = 1'b0;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            dwell_q      <= '0;
            row_q        <= ROW_IDLE;
            found_q      <= 1'b0;
            acc_code_q   <= 4'd0;
            prev_found_q <= 1'b0;
            prev_code_q  <= 4'd0;
            stable_q     <= '0;
            key_code_q   <= 4'd0;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            dwell_q      <= dwell_d;
            row_q        <= row_d;
            found_q      <= found_d;
            acc_code_q   <= acc_code_d;
            prev_found_q <= prev_found_d;
            prev_code_q  <= prev_code_d;
            stable_q     <= stable_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    assign kp.Key_Row   = row_q;
    assign kp.Key_Code  = key_code_q;
    assign kp.Key_Valid = key_valid_q;
    assign kp.Key_Held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4 with a physical keypad model and a frame-level
// reference model of debounce and acceptance.
module tb_keypad_scan_4x4;

    localparam int ST = 4;
    localparam int DB = 2;
    localparam int FRAME = 4 * ST;

    logic        sys_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] mask    = 16'h0;
    logic [3:0]  col;

    always #5 sys_clk = ~sys_clk;

    keypad_scan_4x4_if kp();

    keypad_scan_4x4 #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .kp      (kp)
    );

    // Physical keypad: key (r,c) pressed shorts row r to column c
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!kp.Key_Row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (mask[r*4 + c]) col[c] = 1'b0;
                end
            end
        end
    end
    assign kp.Key_Col = col;

    int         checks = 0;
    int         errors = 0;
    int         t = 0;
    logic [3:0] m_code = 4'd0;
    logic       m_valid = 1'b0;
    logic       m_held = 1'b0;
    logic       m_pfound = 1'b0;
    logic [3:0] m_pcode = 4'd0;
    int         m_cnt = 0;

    function automatic logic [3:0] low_idx(input logic [15:0] m);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 15; i >= 0; i--) if (m[i]) k = 4'(i);
        return k;
    endfunction

    function automatic logic [3:0] exp_row(input int tc);
        logic [3:0] one_hot;
        if (tc < ST) return 4'b1111;
        one_hot = 4'b0001 << (((tc - ST) / ST) % 4);
        return ~one_hot;
    endfunction

    function automatic logic [15:0] rand_mask();
        int          k;
        int          b;
        logic [15:0] m;
        m = 16'h0;
        k = int'($urandom_range(0, 3));
        if (k >= 1) begin b = int'($urandom_range(0, 15)); m[b] = 1'b1; end
        if (k == 3) begin b = int'($urandom_range(0, 15)); m[b] = 1'b1; end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Frame result = lowest pressed key index; debounce on whole frames
    task automatic model_frame_end();
        logic       found;
        logic [3:0] code;
        logic       same;
        found = (mask != 16'h0);
        code  = low_idx(mask);
        same  = (found == m_pfound) && (!found || code == m_pcode);
        if (same) begin
            if (m_cnt < DB) m_cnt++;
        end else begin
            m_cnt    = 1;
            m_pfound = found;
            m_pcode  = code;
        end
        if (m_cnt == DB) begin
            if (found && !m_held) begin
                m_code  = code;
                m_valid = 1'b1;
                m_held  = 1'b1;
            end else if (!found && m_held) begin
                m_held = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        m_valid = 1'b0;
        if (reset) begin
            t        = 0;
            m_code   = 4'd0;
            m_held   = 1'b0;
            m_pfound = 1'b0;
            m_pcode  = 4'd0;
            m_cnt    = 0;
        end else begin
            t++;
            if (t >= 5 * ST && ((t - 5 * ST) % FRAME) == 0) model_frame_end();
        end
        chk("row",   kp.Key_Row,         exp_row(t));
        chk("code",  kp.Key_Code,        m_code);
        chk("valid", {3'b0, kp.Key_Valid}, {3'b0, m_valid});
        chk("held",  {3'b0, kp.Key_Held},  {3'b0, m_held});
    endtask

    task automatic start_scan(input logic [15:0] m);
        mask = m;
        repeat (ST) step();
    endtask

    task automatic frames(input int n, input logic [15:0] m);
        mask = m;
        repeat (n * FRAME) step();
    endtask

    initial begin
        // Reset held for 5 cycles with random column activity
        reset = 1'b1;
        mask  = rand_mask() | 16'h0101;
        repeat (5) step();
        reset = 1'b0;

        // Single key row1/col1 from cycle 0: pulse at cycle 36 with code 5
        start_scan(16'h0020);
        frames(3, 16'h0020);

        // Release: held drops after the second no-press frame
        frames(3, 16'h0000);

        // Bounce on alternate frames, then hold steady
        for (int i = 0; i < 6; i++) frames(1, (i % 2 == 0) ? 16'h0020 : 16'h0000);
        frames(3, 16'h0020);
        frames(3, 16'h0000);

        // Priority: row0/col2 with row2/col0 gives code 2; adding row3/col3 gives no pulse
        frames(3, 16'h0104);
        frames(3, 16'h8104);
        frames(3, 16'h0000);
        frames(3, 16'h8000);
        frames(3, 16'h0000);

        // Reset after one qualifying frame; press must re-qualify from scratch
        frames(1, 16'h0200);
        reset = 1'b1;
        step();
        reset = 1'b0;
        start_scan(16'h0200);
        frames(3, 16'h0200);
        frames(3, 16'h0000);

        // Randomized key activity
        for (int i = 0; i < 30; i++) begin
            frames(int'($urandom_range(1, 3)), rand_mask());
        end
        frames(3, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
